// File: rtl/risc_ctrl_pipe.sv
// Pipelined control unit: decodes the D-stage instruction and carries its control word through E, M and W.
// Optional feature: define CTRL_ILLEGAL_EN to add the IllegalM output and flag illegal encodings.
module risc_ctrl_pipe #(
    parameter int ALU_CTRL_W   = 4,
    parameter int RESULT_SRC_W = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [31:0]             InstrD,
    input  logic                    StallE,
    input  logic                    FlushE,
    input  logic                    ZeroE,
    input  logic                    NegE,
    input  logic                    OvfE,
    input  logic                    CarryE,
    output logic [2:0]              ImmSrcD,
    output logic                    ALUSrcE,
    output logic [ALU_CTRL_W-1:0]   ALUControlE,
    output logic                    JalrE,
    output logic                    PCSrcE,
    output logic                    RegWriteM,
    output logic                    MemWriteM,
    output logic [RESULT_SRC_W-1:0] ResultSrcE,
    output logic [RESULT_SRC_W-1:0] ResultSrcM,
    output logic                    RegWriteW,
    output logic [RESULT_SRC_W-1:0] ResultSrcW
`ifdef CTRL_ILLEGAL_EN
    ,
    output logic                    IllegalM
`endif
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_SLL   = 4'd4;
    localparam logic [3:0] ALU_SRL   = 4'd5;
    localparam logic [3:0] ALU_XOR   = 4'd6;
    localparam logic [3:0] ALU_SLT   = 4'd7;
    localparam logic [3:0] ALU_SRA   = 4'd8;
    localparam logic [3:0] ALU_SLTU  = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    typedef struct packed {
        logic                    reg_write;
        logic                    mem_write;
        logic [RESULT_SRC_W-1:0] result_src;
        logic                    jump;
        logic                    branch;
        logic                    jalr;
        logic                    alu_src;
        logic [ALU_CTRL_W-1:0]   alu_ctrl;
        logic [2:0]              funct3;
`ifdef CTRL_ILLEGAL_EN
        logic                    illegal;
`endif
    } ctrl_e_t;

    typedef struct packed {
        logic                    reg_write;
        logic                    mem_write;
        logic [RESULT_SRC_W-1:0] result_src;
`ifdef CTRL_ILLEGAL_EN
        logic                    illegal;
`endif
    } ctrl_m_t;

    typedef struct packed {
        logic                    reg_write;
        logic [RESULT_SRC_W-1:0] result_src;
    } ctrl_w_t;

    logic [6:0] op;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       f7_ok;
    logic [3:0] alu_ri;
    logic [3:0] alu_code;
    logic [1:0] result_src2;
    logic       unused_instr_bits;
    ctrl_e_t    dec_d, ctrl_e;
    ctrl_m_t    ctrl_m;
    ctrl_w_t    ctrl_w;
    logic       br_cond;

    assign op                = InstrD[6:0];
    assign funct3            = InstrD[14:12];
    assign funct7            = InstrD[31:25];
    assign f7_ok             = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
    assign unused_instr_bits = ^{InstrD[24:15], InstrD[11:7]};

    // funct7[5] selects sub only for R-type add; it selects sra for both R and I shifts
    always_comb begin
        alu_ri = ALU_ADD;
        case (funct3)
            3'b000:  alu_ri = (op == OP_R && funct7[5]) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_ri = ALU_SLL;
            3'b010:  alu_ri = ALU_SLT;
            3'b011:  alu_ri = ALU_SLTU;
            3'b100:  alu_ri = ALU_XOR;
            3'b101:  alu_ri = funct7[5] ? ALU_SRA : ALU_SRL;
            3'b110:  alu_ri = ALU_OR;
            default: alu_ri = ALU_AND;
        endcase
    end

    always_comb begin
        dec_d       = '0;
        ImmSrcD     = 3'b000;
        alu_code    = ALU_ADD;
        result_src2 = 2'b00;
        case (op)
            OP_LW: begin
                dec_d.reg_write = 1'b1;
                dec_d.alu_src   = 1'b1;
                result_src2     = 2'b01;
            end
            OP_SW: begin
                dec_d.alu_src   = 1'b1;
                dec_d.mem_write = 1'b1;
                ImmSrcD         = 3'b001;
            end
            // R-type with an unrecognised funct7 is treated as a bubble
            OP_R: if (f7_ok) begin
                dec_d.reg_write = 1'b1;
                alu_code        = alu_ri;
            end
            OP_I: begin
                dec_d.reg_write = 1'b1;
                dec_d.alu_src   = 1'b1;
                alu_code        = alu_ri;
            end
            OP_B: begin
                dec_d.branch = 1'b1;
                ImmSrcD      = 3'b010;
                alu_code     = ALU_SUB;
            end
            OP_JAL: begin
                dec_d.reg_write = 1'b1;
                dec_d.jump      = 1'b1;
                ImmSrcD         = 3'b011;
                result_src2     = 2'b10;
            end
            OP_JALR: begin
                dec_d.reg_write = 1'b1;
                dec_d.alu_src   = 1'b1;
                dec_d.jump      = 1'b1;
                dec_d.jalr      = 1'b1;
                result_src2     = 2'b10;
            end
            OP_LUI: begin
                dec_d.reg_write = 1'b1;
                dec_d.alu_src   = 1'b1;
                ImmSrcD         = 3'b100;
                alu_code        = ALU_PASSB;
            end
            default: ;
        endcase
        dec_d.alu_ctrl   = ALU_CTRL_W'(alu_code);
        dec_d.result_src = RESULT_SRC_W'(result_src2);
        dec_d.funct3     = funct3;
`ifdef CTRL_ILLEGAL_EN
        dec_d.illegal    = !(op inside {OP_LW, OP_SW, OP_R, OP_I, OP_B, OP_JAL, OP_JALR, OP_LUI})
                           || (op == OP_R && !f7_ok);
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       ctrl_e <= '0;
        else if (FlushE) ctrl_e <= '0;
        else if (!StallE) ctrl_e <= dec_d;
    end

    // A held E instruction must not reach M twice, so M takes a bubble while E is stalled
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       ctrl_m <= '0;
        else if (StallE) ctrl_m <= '0;
        else begin
            ctrl_m.reg_write  <= ctrl_e.reg_write;
            ctrl_m.mem_write  <= ctrl_e.mem_write;
            ctrl_m.result_src <= ctrl_e.result_src;
`ifdef CTRL_ILLEGAL_EN
            ctrl_m.illegal    <= ctrl_e.illegal;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ctrl_w <= '0;
        else begin
            ctrl_w.reg_write  <= ctrl_m.reg_write;
            ctrl_w.result_src <= ctrl_m.result_src;
        end
    end

    always_comb begin
        case (ctrl_e.funct3)
            3'b000:  br_cond = ZeroE;
            3'b001:  br_cond = !ZeroE;
            3'b100:  br_cond = NegE ^ OvfE;
            3'b101:  br_cond = !(NegE ^ OvfE);
            3'b110:  br_cond = !CarryE;
            3'b111:  br_cond = CarryE;
            default: br_cond = 1'b0;
        endcase
    end

    assign PCSrcE      = (ctrl_e.jump || (ctrl_e.branch && br_cond)) && !StallE;
    assign ALUSrcE     = ctrl_e.alu_src;
    assign ALUControlE = ctrl_e.alu_ctrl;
    assign JalrE       = ctrl_e.jalr;
    assign ResultSrcE  = ctrl_e.result_src;
    assign RegWriteM   = ctrl_m.reg_write;
    assign MemWriteM   = ctrl_m.mem_write;
    assign ResultSrcM  = ctrl_m.result_src;
    assign RegWriteW   = ctrl_w.reg_write;
    assign ResultSrcW  = ctrl_w.result_src;
`ifdef CTRL_ILLEGAL_EN
    assign IllegalM    = ctrl_m.illegal;
`endif

endmodule

// File: tb/tb_risc_ctrl_pipe.sv
// Directed bench for risc_ctrl_pipe: decode, branch resolution, stall/flush and reset behaviour.
module tb_risc_ctrl_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] InstrD;
    logic        StallE, FlushE, ZeroE, NegE, OvfE, CarryE;
    logic [2:0]  ImmSrcD;
    logic        ALUSrcE, JalrE, PCSrcE, RegWriteM, MemWriteM, RegWriteW;
    logic [3:0]  ALUControlE;
    logic [1:0]  ResultSrcE, ResultSrcM, ResultSrcW;
`ifdef CTRL_ILLEGAL_EN
    logic        IllegalM;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    risc_ctrl_pipe #(.ALU_CTRL_W(4), .RESULT_SRC_W(2)) dut (
        .clk(clk), .reset(reset), .InstrD(InstrD), .StallE(StallE), .FlushE(FlushE),
        .ZeroE(ZeroE), .NegE(NegE), .OvfE(OvfE), .CarryE(CarryE),
        .ImmSrcD(ImmSrcD), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE), .JalrE(JalrE),
        .PCSrcE(PCSrcE), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
        .ResultSrcE(ResultSrcE), .ResultSrcM(ResultSrcM),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW)
`ifdef CTRL_ILLEGAL_EN
        , .IllegalM(IllegalM)
`endif
    );

    always #5 clk = ~clk;

    localparam logic [31:0] I_ADD   = 32'h003100B3;
    localparam logic [31:0] I_SUB   = 32'h40310133;
    localparam logic [31:0] I_SRAI  = 32'h40315093;
    localparam logic [31:0] I_SLTI  = 32'h0020A093;
    localparam logic [31:0] I_SLTU  = 32'h003130B3;
    localparam logic [31:0] I_XOR   = 32'h003140B3;
    localparam logic [31:0] I_SRA   = 32'h403150B3;
    localparam logic [31:0] I_ADDIN = 32'hC0010093;
    localparam logic [31:0] I_LUI   = 32'h000010B7;
    localparam logic [31:0] I_LW    = 32'h0000A083;
    localparam logic [31:0] I_SW    = 32'h0010A023;
    localparam logic [31:0] I_BEQ   = 32'h00000063;
    localparam logic [31:0] I_BNE   = 32'h00001063;
    localparam logic [31:0] I_BLT   = 32'h00004063;
    localparam logic [31:0] I_B010  = 32'h00002063;
    localparam logic [31:0] I_BGEU  = 32'h00007063;
    localparam logic [31:0] I_JAL   = 32'h0000006F;
    localparam logic [31:0] I_JALR  = 32'h00008067;
    localparam logic [31:0] I_BAD   = 32'h0000007F;
    localparam logic [31:0] I_BADF7 = 32'h023100B3;
    localparam logic [31:0] I_NOP   = 32'h00000000;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic flags(input logic z, input logic n, input logic v, input logic c);
        ZeroE = z; NegE = n; OvfE = v; CarryE = c;
        #1;
    endtask

    initial begin
        reset = 1'b1; InstrD = I_ADD; StallE = 0; FlushE = 0;
        ZeroE = 0; NegE = 0; OvfE = 0; CarryE = 0;
        tick(); tick();
        chk("rst_alusrc", ALUSrcE, 0);
        chk("rst_aluctl", ALUControlE, 0);
        chk("rst_pcsrc", PCSrcE, 0);
        chk("rst_regwm", RegWriteM, 0);
        chk("rst_regww", RegWriteW, 0);
        chk("rst_rsrcw", ResultSrcW, 0);

        // run a jal into E/M, then reset between edges
        reset = 1'b0; InstrD = I_JAL; #1;
        chk("jal_imm", ImmSrcD, 3);
        tick(); tick();
        chk("jal_pc", PCSrcE, 1);
        chk("jal_rsrcm", ResultSrcM, 2);
        reset = 1'b1; #1;
        chk("midrst_pc", PCSrcE, 0);
        chk("midrst_regwm", RegWriteM, 0);
        chk("midrst_rsrcm", ResultSrcM, 0);
        chk("midrst_rsrce", ResultSrcE, 0);
        reset = 1'b0; InstrD = I_ADD;
        tick();
        chk("add_e_ctl", ALUControlE, 0);
        chk("add_e_src", ALUSrcE, 0);
        chk("add_e_regwm", RegWriteM, 0);
        InstrD = I_NOP;
        tick();
        chk("add_m_regw", RegWriteM, 1);
        chk("add_m_w", RegWriteW, 0);
        tick();
        chk("add_w_regw", RegWriteW, 1);
        chk("add_w_regwm", RegWriteM, 0);

        // ALU decode
        InstrD = I_SUB;   tick(); chk("sub", ALUControlE, 1);
        InstrD = I_SRAI;  tick(); chk("srai", ALUControlE, 8); chk("srai_src", ALUSrcE, 1);
        InstrD = I_SLTI;  tick(); chk("slti", ALUControlE, 7);
        InstrD = I_SLTU;  tick(); chk("sltu", ALUControlE, 9);
        InstrD = I_XOR;   tick(); chk("xor", ALUControlE, 6);
        InstrD = I_SRA;   tick(); chk("sra", ALUControlE, 8);
        InstrD = I_ADDIN; tick(); chk("addi_f7", ALUControlE, 0);
        InstrD = I_LUI; #1; chk("lui_imm", ImmSrcD, 4);
        tick(); chk("lui", ALUControlE, 10); chk("lui_src", ALUSrcE, 1);
        InstrD = I_SW; #1; chk("sw_imm", ImmSrcD, 1);
        tick(); InstrD = I_NOP; tick();
        chk("sw_memw", MemWriteM, 1); chk("sw_regw", RegWriteM, 0);

        // branch resolution
        InstrD = I_BNE; #1; chk("b_imm", ImmSrcD, 2);
        tick(); flags(0, 0, 0, 0);
        chk("bne_taken", PCSrcE, 1); chk("b_aluctl", ALUControlE, 1); chk("b_src", ALUSrcE, 0);
        flags(1, 0, 0, 0); chk("bne_nt", PCSrcE, 0);
        InstrD = I_BLT; tick(); flags(0, 1, 1, 0); chk("blt_nv", PCSrcE, 0);
        flags(0, 1, 0, 0); chk("blt_n", PCSrcE, 1);
        InstrD = I_BGEU; tick(); flags(0, 0, 0, 1); chk("bgeu_c", PCSrcE, 1);
        flags(0, 0, 0, 0); chk("bgeu_nc", PCSrcE, 0);
        InstrD = I_BEQ; tick(); flags(0, 0, 0, 0); chk("beq_nz", PCSrcE, 0);
        flags(1, 0, 0, 0); chk("beq_z", PCSrcE, 1);
        InstrD = I_B010; tick(); flags(1, 1, 0, 1); chk("b010", PCSrcE, 0);
        InstrD = I_JAL; tick(); flags(0, 0, 0, 0);
        chk("jal_pc0", PCSrcE, 1); chk("jal_rsrce", ResultSrcE, 2);
        StallE = 1; #1; chk("jal_stall_pc", PCSrcE, 0);
        StallE = 0; #1;
        InstrD = I_JALR; tick();
        chk("jalr", JalrE, 1); chk("jalr_pc", PCSrcE, 1); chk("jalr_src", ALUSrcE, 1);

        // lw held in E for two edges
        InstrD = I_LW; tick();
        InstrD = I_SUB; StallE = 1; #1;
        chk("lw_pc", PCSrcE, 0); chk("lw_rsrce", ResultSrcE, 1);
        tick();
        chk("st1_ctl", ALUControlE, 0); chk("st1_rsrce", ResultSrcE, 1);
        chk("st1_regwm", RegWriteM, 0); chk("st1_pc", PCSrcE, 0);
        tick();
        chk("st2_ctl", ALUControlE, 0); chk("st2_rsrce", ResultSrcE, 1);
        chk("st2_regwm", RegWriteM, 0); chk("st2_pc", PCSrcE, 0);
        StallE = 0;
        tick();
        chk("st3_ctl", ALUControlE, 1);
        chk("st3_regwm", RegWriteM, 1); chk("st3_rsrcm", ResultSrcM, 1);
        InstrD = I_NOP;
        tick();
        chk("st4_rsrcm", ResultSrcM, 0); chk("st4_rsrcw", ResultSrcW, 1);

        // flush beats stall on a taken beq
        InstrD = I_BEQ; tick(); flags(1, 0, 0, 0);
        chk("fl_pre_pc", PCSrcE, 1);
        InstrD = I_ADD; FlushE = 1; StallE = 1;
        tick();
        FlushE = 0; StallE = 0; #1;
        chk("fl_pc", PCSrcE, 0); chk("fl_ctl", ALUControlE, 0);
        chk("fl_src", ALUSrcE, 0); chk("fl_rsrce", ResultSrcE, 0);
        flags(0, 0, 0, 0);
        // flushed add never reaches M
        InstrD = I_ADD; FlushE = 1; tick();
        FlushE = 0; InstrD = I_NOP; tick();
        chk("fl_add_regwm", RegWriteM, 0);

        // illegal encodings decode to bubbles
        InstrD = I_BAD; #1; chk("bad_imm", ImmSrcD, 0);
        tick(); InstrD = I_BADF7;
        chk("bad_e_ctl", ALUControlE, 0); chk("bad_e_src", ALUSrcE, 0);
        tick(); InstrD = I_NOP;
        chk("bad_m_regw", RegWriteM, 0); chk("bad_m_memw", MemWriteM, 0);
`ifdef CTRL_ILLEGAL_EN
        chk("bad_m_ill", IllegalM, 1);
`endif
        chk("badf7_e_ctl", ALUControlE, 0); chk("badf7_e_rsrc", ResultSrcE, 0);
        tick();
        chk("badf7_m_regw", RegWriteM, 0); chk("badf7_m_memw", MemWriteM, 0);
`ifdef CTRL_ILLEGAL_EN
        chk("badf7_m_ill", IllegalM, 1);
        tick();
        chk("nop_m_ill", IllegalM, 1);
        InstrD = I_ADD; tick(); tick();
        chk("add_m_ill", IllegalM, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/risc_ctrl_pipe.md
Name: risc_ctrl_pipe

Overview:
- Parametrised successor to the single-cycle decode controller. Decodes the D-stage instruction and carries the control word through the E, M and W pipeline registers.
- Supports stall and flush of the E stage.
- Resolves the branch/jump redirect (PCSrcE) in E from ALU flags. Covers beq/bne/blt/bge/bltu/bgeu, jalr, lui, xor/slt/sltu/sra.
- Sits between the IF/ID register and the datapath; the hazard unit drives its StallE/FlushE.

Parameters:
ALU_CTRL_W, 4, width of ALUControl code; must be >= 4, upper bits zero-filled.
RESULT_SRC_W, 2, width of ResultSrc select; must be >= 2.

Ports:
clk  in  1  pipeline clock, rising edge
reset  in  1  asynchronous, active-high; clears all E/M/W registers
InstrD  in  32  D-stage instruction (opcode [6:0], funct3 [14:12], funct7 [31:25])
StallE  in  1  hold E-stage control registers
FlushE  in  1  load bubble into E-stage control registers
ZeroE, NegE, OvfE, CarryE  in  1 each  ALU flags of the E-stage operation (CarryE = no borrow on sub)
ImmSrcD  out  3  immediate format: 000 I, 001 S, 010 B, 011 J, 100 U
ALUSrcE  out  1  ALU B operand = immediate
ALUControlE  out  ALU_CTRL_W  ALU operation
JalrE  out  1  jump target comes from ALU result
PCSrcE  out  1  redirect PC this cycle
RegWriteM, MemWriteM  out  1  M-stage enables
ResultSrcE, ResultSrcM  out  RESULT_SRC_W  00 ALU, 01 memory, 10 PC+4, 11 reserved
RegWriteW  out  1  W-stage register write enable
ResultSrcW  out  RESULT_SRC_W  W-stage result select

Behaviour:
- D decode is combinational. Per opcode: {RegWrite, ALUSrc, ImmSrc, MemWrite, ResultSrc, Jump, Branch, Jalr}.
  - lw 0000011: 1,1,000,0,01,0,0,0
  - sw 0100011: 0,1,001,1,00,0,0,0
  - R 0110011: 1,0,000,0,00,0,0,0
  - I 0010011: 1,1,000,0,00,0,0,0
  - B 1100011: 0,0,010,0,00,0,1,0
  - jal 1101111: 1,0,011,0,10,1,0,0
  - jalr 1100111: 1,1,000,0,10,1,0,1
  - lui 0110111: 1,1,100,0,00,0,0,0
  - Any other opcode: all zero (bubble).
- ALU codes:
  - Values: 0 add, 1 sub, 2 and, 3 or, 4 sll, 5 srl, 6 xor, 7 slt, 8 sra, 9 sltu, 10 passB.
  - R/I decode by funct3: 000 add, 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl, 110 or, 111 and.
  - funct7[5]=1 gives sub only for R-type funct3 000; gives sra for funct3 101 in both R and I.
  - I-type addi ignores funct7.
  - B: sub for funct3 0xx, sltu-compatible sub for 11x (code 1 in both cases).
  - lui: passB.
  - lw, sw, jal, jalr: add.
- E register (D->E) holds RegWrite, MemWrite, ResultSrc, Jump, Branch, Jalr, ALUSrc, ALUControl and funct3.
  - FlushE=1: loads all zeros at next edge.
  - Else StallE=1: holds its value.
  - Else: loads the D decode.
  - FlushE has priority over StallE.
- Branch condition from funct3E:
  - 000 Z; 001 !Z; 100 N^V; 101 !(N^V); 110 !C; 111 C.
  - 010/011: condition false.
- PCSrcE = (JumpE | (BranchE & cond)) & !StallE. Combinational from E registers and flags; no redirect while E is held.
- M register: loads E controls each edge. When StallE=1 it loads a bubble (all zero) so a held instruction is not duplicated downstream.
- W register: loads M controls every edge, unconditionally.
- Latency: D decode reaches E outputs 1 edge later, M 2 edges, W 3 edges.
- Reset: asynchronous; all E/M/W outputs 0 immediately. PCSrcE=0, ALUControlE=0, ResultSrc*=0. Reset mid-stream drops all in-flight controls; the first post-reset edge loads the current D decode.

Optional Feature:
- Macro CTRL_ILLEGAL_EN.
- Defined:
  - Adds output IllegalM (1). IllegalD flags any unlisted opcode, and R-type funct7 not in {0000000, 0100000}.
  - IllegalD travels in the E/M registers with the same flush/stall/bubble rules.
  - An illegal instruction still decodes to all-zero controls.
- Undefined: no IllegalM port, no extra flops; unlisted opcodes silently become bubbles.

Test Plan:
- Reset asserted between edges: all outputs drop to 0 before the next edge. After release, add x1,x2,x3 (0x003100B3) gives RegWriteE=1, ALUControlE=0, then RegWriteM=1, then RegWriteW=1 on successive edges.
- sub 0x40310133, srai 0x40315093, slti 0x0020A093: ALUControlE = 1, 8, 7 respectively. sltu gives 9; lui 0x000010B7 gives 10 with ImmSrcD=100.
- Branch table: bne with ZeroE=0 gives PCSrcE=1. blt with NegE=1,OvfE=1 gives 0. bgeu with CarryE=1 gives 1. beq with ZeroE=0 gives 0. jal gives PCSrcE=1 regardless of flags. jalr gives JalrE=1.
- lw in E with StallE=1 for 2 cycles: ALUControlE and ResultSrcE=01 held. RegWriteM=0 for 2 cycles, then a single RegWriteM=1 with ResultSrcM=01. PCSrcE stays 0 throughout.
- Taken beq in E with FlushE=1 and StallE=1 in the same cycle: the next E contents are all zero, so the flush wins.
- With CTRL_ILLEGAL_EN: opcode 0x7F, then funct7=0000001 R-type. IllegalM=1 two edges later in each case with RegWriteM=0 and MemWriteM=0. Without the macro, the same stimulus gives all-zero controls.
